// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit LSU to 16-bit async SRAM responder.
// Holds the controller state encoding, half-select constants and bus widths.
// No logic lives here; everything is consumed by sram_ctrl_32b_resp.
package sram_ctrl_pkg;

  localparam int SRAM_AW      = 18;
  localparam int SRAM_DW      = 16;
  localparam int WAIT_CYC_DEF = 1;

  // Halfword select carried in SRAM_ADDR[0]
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_LO_REC,
    WR_HI,
    WR_HI_REC,
    DONE
  } sram_state_e;

endpackage

// File: rtl/sram_ctrl_32b_resp.sv
// Executes one 32-bit LSU read/write as two 16-bit accesses on an async SRAM.
// Latency: read 2*WAIT_CYC+1 cycles; write up to 2*(WAIT_CYC+1)+1; mask-0 write 1.
// Backpressure: LSU holds the request stable until the single-cycle o_ACK pulse.
module sram_ctrl_32b_resp
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [17:0]        i_ADDR,
  input  logic [31:0]        i_WDATA,
  input  logic [3:0]         i_BMASK,
  input  logic               i_WREN,
  input  logic               i_RDEN,
  output logic [31:0]        o_RDATA,
  output logic               o_ACK,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

  sram_state_e  state_q, state_d;
  logic [3:0]   wait_q, wait_d;
  logic [15:0]  addr_q;
  logic [31:0]  wdata_q;
  logic [3:0]   mask_q;
  logic [31:0]  rdata_q;

  logic               timed_st;
  logic               last_cyc;
  logic               take_req;
  logic               half;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_dat;

  // Byte offset bits are meaningless for a word-wide port
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_ADDR[1:0];

  assign timed_st = (state_q == RD_LO) || (state_q == RD_HI) ||
                    (state_q == WR_LO) || (state_q == WR_HI);
  assign last_cyc = timed_st && (wait_q == WAIT_LAST);
  assign take_req = (state_q == IDLE) && (i_WREN || i_RDEN);

  // State register, access-length counter, request latch and read capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (take_req) begin
        addr_q  <= i_ADDR[17:2];
        wdata_q <= i_WDATA;
        mask_q  <= i_WREN ? i_BMASK : 4'b0000;
      end
      if (state_q == RD_LO && last_cyc) rdata_q[15:0]  <= SRAM_DQ;
      if (state_q == RD_HI && last_cyc) rdata_q[31:16] <= SRAM_DQ;
    end
  end

  // Next-state: writes win over reads; empty masks skip their half entirely
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    if (timed_st && !last_cyc) wait_d = wait_q + 4'd1;
    unique case (state_q)
      IDLE: begin
        if (i_WREN) begin
          if (|i_BMASK[1:0])      state_d = WR_LO;
          else if (|i_BMASK[3:2]) state_d = WR_HI;
          else                    state_d = DONE;
        end else if (i_RDEN) begin
          state_d = RD_LO;
        end
      end
      RD_LO:     if (last_cyc) state_d = RD_HI;
      RD_HI:     if (last_cyc) state_d = DONE;
      WR_LO:     if (last_cyc) state_d = WR_LO_REC;
      WR_LO_REC: state_d = (|mask_q[3:2]) ? WR_HI : DONE;
      WR_HI:     if (last_cyc) state_d = WR_HI_REC;
      WR_HI_REC: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // SRAM pin decode; recovery states keep address/data/lanes with WE released
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_UB_N = 1'b1;
    half      = HALF_LO;
    dq_oe     = 1'b0;
    dq_dat    = wdata_q[15:0];
    o_ACK     = 1'b0;
    unique case (state_q)
      RD_LO, RD_HI: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_UB_N = 1'b0;
        half      = (state_q == RD_HI) ? HALF_HI : HALF_LO;
      end
      WR_LO, WR_LO_REC: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = (state_q == WR_LO) ? 1'b0 : 1'b1;
        SRAM_LB_N = ~mask_q[0];
        SRAM_UB_N = ~mask_q[1];
        dq_oe     = 1'b1;
      end
      WR_HI, WR_HI_REC: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = (state_q == WR_HI) ? 1'b0 : 1'b1;
        SRAM_LB_N = ~mask_q[2];
        SRAM_UB_N = ~mask_q[3];
        half      = HALF_HI;
        dq_oe     = 1'b1;
        dq_dat    = wdata_q[31:16];
      end
      DONE:    o_ACK = 1'b1;
      default: ;
    endcase
  end

  assign SRAM_ADDR = {1'b0, addr_q, half};
  assign o_RDATA   = rdata_q;
  assign SRAM_DQ   = dq_oe ? dq_dat : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_32b_resp.sv
module tb_sram_ctrl_32b_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance with WAIT_CYC=1
  logic [17:0] a_i = '0;
  logic [31:0] wd_i = '0;
  logic [3:0]  m_i = '0;
  logic        wren = 1'b0, rden = 1'b0;
  logic [31:0] rdata;
  logic        ack;
  logic [17:0] sa;
  wire  [15:0] dq;
  logic        ce_n, we_n, oe_n, lb_n, ub_n;

  sram_ctrl_32b_resp #(.WAIT_CYC(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_ADDR(a_i), .i_WDATA(wd_i), .i_BMASK(m_i),
    .i_WREN(wren), .i_RDEN(rden), .o_RDATA(rdata), .o_ACK(ack),
    .SRAM_ADDR(sa), .SRAM_DQ(dq), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );

  // Instance with WAIT_CYC=3, read-only use
  logic [17:0] a3 = '0;
  logic        rden3 = 1'b0;
  logic [31:0] rdata3;
  logic        ack3;
  logic [17:0] sa3;
  wire  [15:0] dq3;
  logic        ce3_n, we3_n, oe3_n, lb3_n, ub3_n;

  sram_ctrl_32b_resp #(.WAIT_CYC(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_ADDR(a3), .i_WDATA(32'h0), .i_BMASK(4'h0),
    .i_WREN(1'b0), .i_RDEN(rden3), .o_RDATA(rdata3), .o_ACK(ack3),
    .SRAM_ADDR(sa3), .SRAM_DQ(dq3), .SRAM_CE_N(ce3_n), .SRAM_WE_N(we3_n),
    .SRAM_OE_N(oe3_n), .SRAM_LB_N(lb3_n), .SRAM_UB_N(ub3_n)
  );

  // SRAM models: drive on read, commit byte lanes while WE_N is low
  logic [15:0] mem  [0:255];
  logic [15:0] mem3 [0:3];
  assign dq  = (!ce_n  && !oe_n  && we_n)  ? mem[sa[7:0]]   : 16'hzzzz;
  assign dq3 = (!ce3_n && !oe3_n && we3_n) ? mem3[sa3[1:0]] : 16'hzzzz;

  logic [17:0] wlog_a  [$];
  logic [15:0] wlog_d  [$];
  logic [1:0]  wlog_be [$];
  int ce_cnt = 0, ack_cnt = 0, rd0_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!ce_n) ce_cnt++;
      if (ack) ack_cnt++;
      if (!ce_n && !oe_n && sa == 18'h0) rd0_cnt++;
      if (!ce_n && !we_n) begin
        if (!lb_n) mem[sa[7:0]][7:0]  <= dq[7:0];
        if (!ub_n) mem[sa[7:0]][15:8] <= dq[15:8];
        wlog_a.push_back(sa);
        wlog_d.push_back(dq);
        wlog_be.push_back({ub_n, lb_n});
      end
      if (!oe_n)  chk("oe_we_excl",  {31'h0, we_n},  32'h1);
      if (!oe3_n) chk("oe_we_excl3", {31'h0, we3_n}, 32'h1);
    end
  end

  // One LSU transaction on the WAIT_CYC=1 instance; lat counts edges from sampling to o_ACK
  task automatic txn(input logic wr, input logic rd, input logic [17:0] a,
                     input logic [31:0] d, input logic [3:0] m, output int lat);
    wlog_a.delete(); wlog_d.delete(); wlog_be.delete();
    a_i = a; wd_i = d; m_i = m; wren = wr; rden = rd;
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack) break;
      if (lat > 40) begin
        n_cmp++; n_err++;
        $error("FAIL ack_timeout: observed no o_ACK after %0d cycles expected one", lat);
        break;
      end
    end
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {31'h0, ack}, 32'h0);
  endtask

  initial begin
    int lat, c0, k0, r0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem3[0] = 16'h0; mem3[1] = 16'h0; mem3[2] = 16'hBBBB; mem3[3] = 16'hAAAA;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl_n", {27'h0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", {14'h0, sa}, 32'h0);
    chk("rst_rdata3", rdata3, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full write then read
    txn(1'b1, 1'b0, 18'h00104, 32'hDEADBEEF, 4'b1111, lat);
    chk("fw_lat", lat, 5);
    chk("fw_nwr", wlog_a.size(), 2);
    if (wlog_a.size() == 2) begin
      chk("fw_a0", {14'h0, wlog_a[0]}, 32'h82);
      chk("fw_d0", {16'h0, wlog_d[0]}, 32'hBEEF);
      chk("fw_a1", {14'h0, wlog_a[1]}, 32'h83);
      chk("fw_d1", {16'h0, wlog_d[1]}, 32'hDEAD);
      chk("fw_be", {28'h0, wlog_be[0], wlog_be[1]}, 32'h0);
    end
    txn(1'b0, 1'b1, 18'h00104, 32'h0, 4'b0000, lat);
    chk("fr_lat", lat, 3);
    chk("fr_data", rdata, 32'hDEADBEEF);

    // Byte write into lane 2 of an existing word
    txn(1'b1, 1'b0, 18'h00008, 32'h11223344, 4'b1111, lat);
    txn(1'b1, 1'b0, 18'h00008, 32'h00AA0000, 4'b0100, lat);
    chk("bw_lat", lat, 3);
    chk("bw_nwr", wlog_a.size(), 1);
    if (wlog_a.size() == 1) begin
      chk("bw_addr", {14'h0, wlog_a[0]}, 32'h5);
      chk("bw_be_ub_lb", {30'h0, wlog_be[0]}, 32'h2);
    end
    txn(1'b0, 1'b1, 18'h00008, 32'h0, 4'b0000, lat);
    chk("bw_rdback", rdata, 32'h11AA3344);

    // Mask-0 write: acknowledged with no SRAM activity
    c0 = ce_cnt;
    txn(1'b1, 1'b0, 18'h00008, 32'hFFFFFFFF, 4'b0000, lat);
    chk("m0_lat", lat, 1);
    chk("m0_ce_cycles", ce_cnt - c0, 0);
    chk("m0_mem", {mem[5], mem[4]}, 32'h11AA3344);

    // Write and read requested together: write wins, o_RDATA untouched
    txn(1'b1, 1'b1, 18'h00010, 32'hCAFEF00D, 4'b1111, lat);
    chk("wr_rd_lat", lat, 5);
    chk("wr_rd_nwr", wlog_a.size(), 2);
    chk("wr_rd_mem", {mem[9], mem[8]}, 32'hCAFEF00D);
    chk("wr_rd_rdata", rdata, 32'h11AA3344);

    // Back-to-back reads, request switched the cycle after o_ACK
    k0 = ack_cnt; r0 = rd0_cnt;
    txn(1'b0, 1'b1, 18'h00000, 32'h0, 4'b0000, lat);
    chk("b2b0_data", rdata, 32'h22221111);
    txn(1'b0, 1'b1, 18'h00004, 32'h0, 4'b0000, lat);
    chk("b2b1_data", rdata, 32'h44443333);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b2b_acks", ack_cnt - k0, 2);
    chk("b2b_rd0_once", rd0_cnt - r0, 1);

    // Reset in the middle of WR_LO
    @(posedge clk); #1;
    a_i = 18'h00020; wd_i = 32'h12345678; m_i = 4'b1111; wren = 1'b1;
    @(posedge clk); #1;
    chk("mid_we_low", {31'h0, we_n}, 32'h0);
    rst = 1'b1;
    k0 = ack_cnt;
    @(posedge clk); #1;
    chk("mid_rst_ctl", {29'h0, ce_n, we_n, oe_n}, 32'h7);
    chk("mid_rst_ack", {31'h0, ack}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    wren = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_noack", ack_cnt - k0, 0);
    txn(1'b0, 1'b1, 18'h00104, 32'h0, 4'b0000, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", rdata, 32'hDEADBEEF);

    // WAIT_CYC=3 read
    @(posedge clk); #1;
    a3 = 18'h00004; rden3 = 1'b1;
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack3 || lat > 40) break;
    end
    chk("w3_lat", lat, 7);
    chk("w3_data", rdata3, 32'hAAAABBBB);
    @(posedge clk); #1;
    rden3 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
